// File: rtl/scalar_issue_stage_if.sv
// scalar_issue_stage_if: issue-stage bundle of decoded instruction, writeback, flush and ALU operand signals.
interface scalar_issue_stage_if #(
    parameter int W  = 16,
    parameter int IW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_rd;
    logic [IW-1:0] in_rs1;
    logic [IW-1:0] in_rs2;
    logic [W-1:0]  in_imm;
    logic          in_use_imm;
    logic [2:0]    in_sel;
    logic          in_wb_en;
    logic          wb_en;
    logic [IW-1:0] wb_rd;
    logic [W-1:0]  wb_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_A;
    logic [W-1:0]  out_B;
    logic [2:0]    out_sel;
    logic [IW-1:0] out_rd;
    logic          out_wb_en;

    modport slave (
        input  in_valid, in_rd, in_rs1, in_rs2, in_imm, in_use_imm, in_sel, in_wb_en,
        input  wb_en, wb_rd, wb_data, flush, out_ready,
        output in_ready, out_valid, out_A, out_B, out_sel, out_rd, out_wb_en
    );

    modport master (
        output in_valid, in_rd, in_rs1, in_rs2, in_imm, in_use_imm, in_sel, in_wb_en,
        output wb_en, wb_rd, wb_data, flush, out_ready,
        input  in_ready, out_valid, out_A, out_B, out_sel, out_rd, out_wb_en
    );
endinterface

// File: rtl/scalar_issue_stage.sv
// scalar_issue_stage: register file read, scoreboard hazard check and one-entry operand register toward the ALU.
module scalar_issue_stage #(
    parameter int W     = 16,
    parameter int NREGS = 16
) (
    input logic                clk,
    input logic                rst_n,
    scalar_issue_stage_if.slave bus
);
    logic [W-1:0]     regFile [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] wbMask;
    logic [NREGS-1:0] setMask;
    logic [NREGS-1:0] effPending;
    logic [W-1:0]     rs1Val;
    logic [W-1:0]     rs2Val;
    logic             hazard;
    logic             accept;

    // A writeback landing this cycle both resolves the hazard and forwards its data.
    always_comb begin
        wbMask = bus.wb_en ? NREGS'(1) << bus.wb_rd : '0;
        effPending = pending & ~wbMask;
        hazard = bus.in_valid && (effPending[bus.in_rs1] ||
                 (!bus.in_use_imm && effPending[bus.in_rs2]) ||
                 (bus.in_wb_en && effPending[bus.in_rd]));
        bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard && !bus.flush;
        accept = bus.in_valid && bus.in_ready;
        setMask = (accept && bus.in_wb_en) ? NREGS'(1) << bus.in_rd : '0;
        setMask[0] = 1'b0;
        rs1Val = bus.in_rs1 == '0 ? '0 :
                 (bus.wb_en && bus.wb_rd == bus.in_rs1) ? bus.wb_data : regFile[bus.in_rs1];
        rs2Val = bus.in_rs2 == '0 ? '0 :
                 (bus.wb_en && bus.wb_rd == bus.in_rs2) ? bus.wb_data : regFile[bus.in_rs2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
        end else if (bus.wb_en && bus.wb_rd != '0) begin
            regFile[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Set is ORed in after the clear so a same-cycle issue to the written register stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= bus.flush ? '0 : (pending & ~wbMask) | setMask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_A     <= '0;
            bus.out_B     <= '0;
            bus.out_sel   <= '0;
            bus.out_rd    <= '0;
            bus.out_wb_en <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_A     <= rs1Val;
            bus.out_B     <= bus.in_use_imm ? bus.in_imm : rs2Val;
            bus.out_sel   <= bus.in_sel;
            bus.out_rd    <= bus.in_rd;
            bus.out_wb_en <= bus.in_wb_en;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/scalar_issue_stage.md
SCALAR_ISSUE_STAGE -- requirements
Module: scalar_issue_stage

Interface
REQ-001 Parameters SHALL be: W, 16, datapath width; NREGS, 16, scalar register count (index width 4).
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts instruction this cycle.
- in_rd / in_rs1 / in_rs2  in  4 each  destination / source register indices.
- in_imm  in  16  immediate operand.
- in_use_imm  in  1  B operand from in_imm, not rs2.
- in_sel  in  3  ALU op: 000 add, 001 sub, 010 mul, 011 div, 100 asr, 101 lsr, 110 lsl, 111 and.
- in_wb_en  in  1  instruction writes rd.
- wb_en  in  1  writeback strobe from downstream.
- wb_rd  in  4  writeback register index.
- wb_data  in  16  writeback value.
- flush  in  1  discard output stage and scoreboard.
- out_valid  out  1  operands valid toward ALU.
- out_ready  in  1  downstream consumes operands.
- out_A / out_B  out  16 each  ALU operands A, B.
- out_sel  out  3  ALU op select.
- out_rd  out  4  destination index.
- out_wb_en  out  1  destination write enable.

Function
REQ-003 Block SHALL hold a 16 x 16-bit register file; R0 SHALL read 0, ignore writes, never be pending.
REQ-004 Block SHALL keep one pending bit per register; bit set on accept of instruction with in_wb_en=1 and in_rd!=0, cleared when wb_en=1 and wb_rd matches.
REQ-005 Effective pending SHALL be pending[r] AND NOT (wb_en AND wb_rd==r), i.e. same-cycle writeback resolves hazard.
REQ-006 Hazard SHALL be asserted when in_valid and any of: rs1 effective-pending; rs2 effective-pending with in_use_imm=0; in_wb_en=1 and rd effective-pending (WAW).
REQ-007 in_ready SHALL equal (NOT out_valid OR out_ready) AND NOT hazard AND NOT flush.
REQ-008 Accept (in_valid AND in_ready) SHALL load output register next edge: out_A=rs1 value, out_B=in_use_imm ? in_imm : rs2 value, out_sel, out_rd, out_wb_en copied; out_valid=1.
REQ-009 Register reads SHALL bypass: if wb_en and wb_rd==source index (non-zero), wb_data SHALL be used.
REQ-010 Latency SHALL be exactly 1 cycle accept-to-out_valid; throughput 1 instruction/cycle absent hazards/backpressure.
REQ-011 When out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-012 When out_ready=1 and no accept, out_valid SHALL clear next edge; out_A/out_B/out_sel/out_rd hold last value.
REQ-013 If accept sets and writeback clears same register same cycle, set SHALL win.
REQ-014 Writeback to register file SHALL occur every cycle wb_en=1 regardless of stall, flush or backpressure.
REQ-015 flush SHALL clear out_valid and all pending bits next edge; no accept in flush cycle; concurrent writeback still updates register file.
REQ-016 wb_en to a non-pending register SHALL update data and leave pending bits unchanged.

Reset
REQ-017 rst_n low SHALL immediately clear all 16 registers, all pending bits, out_valid, out_A, out_B, out_sel, out_rd, out_wb_en to 0; in_ready follows REQ-007 (=1 when in_valid=0 or no hazard).
REQ-018 Reset asserted mid-operation SHALL drop in-flight instruction; first accept possible on first rising edge after rst_n high.

Verification
REQ-019 Writeback R1=8, R2=5, then issue add rd=3 rs1=1 rs2=2 -> next cycle out_valid=1, out_A=8, out_B=5, out_sel=000, out_rd=3.
REQ-020 Issue rd=4 (wb_en=1), then rs1=4 instruction while R4 pending -> in_ready=0 until wb_en, wb_rd=4, wb_data=20; same cycle in_ready=1, next cycle out_A=20.
REQ-021 Issue lsl rs1=1 (R1=4), use_imm=1, imm=2, out_ready=0 for 3 cycles -> out_A=4, out_B=2, out_sel=110 held stable, in_ready=0; consumed on out_ready=1.
REQ-022 Issue reading R0 with rs2=0 after wb_en, wb_rd=0, wb_data=0xFFFF -> out_A=0, out_B=0, no stall.
REQ-023 Set R5 pending, assert flush -> next cycle out_valid=0, instruction reading R5 accepted without stall.
REQ-024 Assert rst_n=0 with out_valid=1 between edges -> out_valid=0 and out_A=0 immediately, R1 reads 0 afterward.
